// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 widths, padder state encoding and byte-mask helper.
package sha1_pkg;

    localparam int BlockWidth = 512;
    localparam int WordWidth  = 32;
    localparam int LenWidth   = 64;

    typedef enum logic [1:0] {ABSORB, FULL, PAD1, FINAL} sha1_pad_state_e;

    // Keeps the first b bytes (big-endian) of a word; b >= 4 keeps the whole word.
    function automatic logic [WordWidth-1:0] byte_mask(input logic [2:0] b);
        return b >= 3'd4 ? {WordWidth{1'b1}} : ~({WordWidth{1'b1}} >> {b, 3'b000});
    endfunction

endpackage

// File: rtl/sha1_padder.sv
// sha1_padder: packs a 32-bit big-endian word stream into FIPS 180-4 padded 512-bit blocks.
module sha1_padder
    import sha1_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WordWidth-1:0]  msg_data_i,
    input  logic                  msg_valid_i,
    input  logic                  msg_last_i,
    input  logic [2:0]            msg_bytes_i,
    output logic                  msg_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    output logic                  block_last_o,
    input  logic                  block_ready_i,
    output logic                  error_o
);

    sha1_pad_state_e       state;
    logic [3:0]            idx;
    logic [LenWidth-1:0]   len;
    logic [LenWidth-1:0]   len_new;
    logic                  pend;
    logic [2:0]            b;
    logic [6:0]            p;
    logic [BlockWidth-1:0] nb;
    logic                  acc;
    logic                  out_hs;

    assign msg_ready_o = state == ABSORB;
    assign acc         = msg_valid_i && msg_ready_o;
    assign out_hs      = block_valid_o && block_ready_i;
    assign b           = msg_bytes_i > 3'd4 ? 3'd4 : msg_bytes_i;
    assign p           = {1'b0, idx, 2'b00} + {4'b0000, b};
    assign len_new     = len + (msg_last_i ? LenWidth'({b, 3'b000}) : LenWidth'(32));

    // The buffer and block_o are the same register: it is only observed while valid.
    always_comb begin
        nb = block_o;
        nb[BlockWidth-1-WordWidth*int'(idx) -: WordWidth] = msg_last_i ? msg_data_i & byte_mask(b) : msg_data_i;
        if (msg_last_i && p < 7'd64) nb[BlockWidth-1-8*int'(p) -: 8] = 8'h80;
        if (msg_last_i && p <= 7'd55) nb[LenWidth-1:0] = len_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ABSORB;
            idx           <= '0;
            len           <= '0;
            pend          <= 1'b0;
            block_o       <= '0;
            block_valid_o <= 1'b0;
            block_last_o  <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            case (state)
                ABSORB: if (acc) begin
                    block_o <= nb;
                    len     <= len_new;
                    idx     <= idx + 4'd1;
                    if (msg_last_i) begin
                        error_o       <= error_o || msg_bytes_i > 3'd4;
                        pend          <= p == 7'd64;
                        state         <= p <= 7'd55 ? FINAL : PAD1;
                        block_valid_o <= 1'b1;
                        block_last_o  <= p <= 7'd55;
                    end else if (idx == 4'd15) begin
                        state         <= FULL;
                        block_valid_o <= 1'b1;
                        block_last_o  <= 1'b0;
                    end
                end
                FULL: if (out_hs) begin
                    block_o       <= '0;
                    idx           <= '0;
                    block_valid_o <= 1'b0;
                    state         <= ABSORB;
                end
                // Length-only block; carries the marker when the message filled the previous block exactly.
                PAD1: if (out_hs) begin
                    block_o      <= {(pend ? 8'h80 : 8'h00), {(BlockWidth-8-LenWidth){1'b0}}, len};
                    block_last_o <= 1'b1;
                    state        <= FINAL;
                end
                FINAL: if (out_hs) begin
                    block_o       <= '0;
                    idx           <= '0;
                    len           <= '0;
                    pend          <= 1'b0;
                    block_valid_o <= 1'b0;
                    block_last_o  <= 1'b0;
                    state         <= ABSORB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: directed and random messages checked against a byte-level FIPS 180-4 padding model.
module tb_sha1_padder;
    import sha1_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [WordWidth-1:0]  msg_data_i = '0;
    logic                  msg_valid_i = 1'b0;
    logic                  msg_last_i = 1'b0;
    logic [2:0]            msg_bytes_i = '0;
    logic                  msg_ready_o;
    logic [BlockWidth-1:0] block_o;
    logic                  block_valid_o;
    logic                  block_last_o;
    logic                  block_ready_i = 1'b0;
    logic                  error_o;

    int checks = 0;
    int errors = 0;
    logic [BlockWidth-1:0] exp_blk[$];
    logic                  exp_last[$];
    byte unsigned          msg[$];

    sha1_padder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i),
        .msg_bytes_i(msg_bytes_i), .msg_ready_o(msg_ready_o),
        .block_o(block_o), .block_valid_o(block_valid_o), .block_last_o(block_last_o),
        .block_ready_i(block_ready_i), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [BlockWidth-1:0] obs, input logic [BlockWidth-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length.
    task automatic build(input byte unsigned m[$]);
        byte unsigned pad[$];
        logic [63:0] bl;
        logic [BlockWidth-1:0] blk;
        int nblk;
        pad = m;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bl[8*i +: 8]);
        nblk = pad.size() / 64;
        exp_blk.delete();
        exp_last.delete();
        for (int k = 0; k < nblk; k++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[BlockWidth-1-8*j -: 8] = pad[64*k+j];
            exp_blk.push_back(blk);
            exp_last.push_back(k == nblk - 1);
        end
    endtask

    task automatic gen(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic put_word(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
        int n = 0;
        while (!msg_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!msg_ready_o) check("ready_timeout", msg_ready_o, 1);
        msg_data_i  = d;
        msg_last_i  = last;
        msg_bytes_i = nbytes;
        msg_valid_i = 1'b1;
        @(posedge clk_i); #1;
        msg_valid_i = 1'b0;
    endtask

    task automatic drain(input int stall);
        int guard = 0;
        while (block_valid_o && guard < 4) begin
            guard++;
            if (exp_blk.size() == 0) begin
                check("extra_block", block_valid_o, 0);
                break;
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk_i); #1;
                check("stall_block", block_o, exp_blk[0]);
                check("stall_valid", block_valid_o, 1);
                check("stall_ready", msg_ready_o, 0);
            end
            check("block", block_o, exp_blk[0]);
            check("block_last", block_last_o, exp_last[0]);
            void'(exp_blk.pop_front());
            void'(exp_last.pop_front());
            block_ready_i = 1'b1;
            @(posedge clk_i); #1;
            block_ready_i = 1'b0;
        end
    endtask

    // bad != 0 sends that illegal byte count on the last word, which must act as 4.
    task automatic run_msg(input byte unsigned m[$], input logic [2:0] bad, input int stall);
        int n;
        int nw;
        int lb;
        logic [31:0] d;
        n  = m.size();
        nw = n == 0 ? 1 : (n + 3) / 4;
        build(m);
        for (int w = 0; w < nw; w++) begin
            d  = $urandom;
            lb = (w == nw - 1) ? n - 4 * w : 4;
            for (int j = 0; j < lb; j++) d[31-8*j -: 8] = m[4*w+j];
            put_word(d, w == nw - 1,
                     w == nw - 1 ? (bad != 0 ? bad : 3'(lb)) : 3'($urandom_range(0, 7)));
            check("valid_rise", block_valid_o, (w == nw - 1) || (w % 16 == 15));
            drain(stall);
        end
        check("blocks_left", exp_blk.size(), 0);
        check("ready_idle", msg_ready_o, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", msg_ready_o, 1);
        check("rst_valid", block_valid_o, 0);
        check("rst_last", block_last_o, 0);
        check("rst_block", block_o, 0);
        check("rst_error", error_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 3'd0, 5);
        msg.delete();
        run_msg(msg, 3'd0, 0);
        gen(55); run_msg(msg, 3'd0, 1);
        gen(56); run_msg(msg, 3'd0, 0);
        gen(64); run_msg(msg, 3'd0, 2);
        gen(60); run_msg(msg, 3'd0, 0);
        gen(63); run_msg(msg, 3'd0, 0);
        check("error_clean", error_o, 0);

        gen(8); run_msg(msg, 3'd6, 0);
        check("error_set", error_o, 1);
        gen(64); run_msg(msg, 3'd7, 0);
        gen(5); run_msg(msg, 3'd0, 0);
        check("error_sticky", error_o, 1);

        for (int t = 0; t < 30; t++) begin
            gen($urandom_range(0, 200));
            run_msg(msg, 3'd0, $urandom_range(0, 2));
        end

        // Abandon a partial message with a mid-stream reset.
        for (int w = 0; w < 5; w++) put_word($urandom, 1'b0, 3'd4);
        rst_ni = 1'b0;
        #2;
        check("mid_rst_ready", msg_ready_o, 1);
        check("mid_rst_valid", block_valid_o, 0);
        check("mid_rst_block", block_o, 0);
        check("mid_rst_error", error_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 3'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
